// File: rtl/dmem_pkg.sv
// ============================================================================
// dmem_pkg : shared widths, FSM encoding and latency limits for dmem_latency_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

   localparam int ADDR_W  = 7;
   localparam int DATA_W  = 32;
   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 15;
   localparam int CNT_W   = 4;
   localparam int STAT_W  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   function automatic bit lat_ok(input int lat);
      return (lat >= LAT_MIN) && (lat <= LAT_MAX);
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// ============================================================================
// dmem_array : DEPTH x DW synchronous single-port RAM with registered read data
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dmem_array #(
   parameter int DEPTH = 128,
   parameter int AW    = 7,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic          i_re,
   input  logic [AW-1:0] i_addr,
   input  logic [DW-1:0] i_din,
   output logic [DW-1:0] o_dout
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_dout;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_din;
      end
   end

   // Read data is held between loads so the last load value stays visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dout <= '0;
      end else if (i_re) begin
         r_dout <= r_mem[i_addr];
      end
   end

   assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/dmem_latency_ctrl.sv
// ============================================================================
// dmem_latency_ctrl : fixed-latency data-memory slave for the DM port
//                     (optional macro DMEM_STATS_EN adds ld_count/st_count)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module dmem_latency_ctrl
   import dmem_pkg::*;
#(
   parameter int LATENCY   = 3,
   parameter int DEPTH     = 128,
   parameter int INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              DMena,
   input  logic              DMwea,
   input  logic [ADDR_W-1:0] DMaddra,
   input  logic [DATA_W-1:0] DMdina,
   output logic [DATA_W-1:0] DMdouta,
   output logic              DMdone,
   output logic              DMerr
`ifdef DMEM_STATS_EN
   ,
   output logic [STAT_W-1:0] ld_count,
   output logic [STAT_W-1:0] st_count
`endif
);

   localparam int ARR_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(LATENCY - 1);
   localparam bit c_single = (LATENCY == 1);

   if (!lat_ok(LATENCY) || DEPTH < 1 || DEPTH > (1 << ADDR_W) ||
       (INIT_ZERO != 0 && INIT_ZERO != 1)) begin : g_cfg_bad
      $error("dmem_latency_ctrl: illegal LATENCY/DEPTH/INIT_ZERO");
   end

   dmem_state_t       r_state;
   dmem_state_t       w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic              r_oor;
   logic              r_ld_oor;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_din;

   logic              w_in_oor;
   logic              w_acc;
   logic              w_sel_we;
   logic              w_sel_oor;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_din;
   logic              w_arr_we;
   logic              w_arr_re;
   logic [DATA_W-1:0] w_arr_dout;

   assign w_in_oor = (32'(DMaddra) >= DEPTH);

   // The access happens on the edge that enters DONE; with LATENCY=1 that is
   // the accepting edge itself, so the live inputs are used instead of the
   // captured copy.
   assign w_acc = (r_state == IDLE && DMena && c_single) ||
                  (r_state == BUSY && r_cnt == c_cnt_one);

   assign w_sel_we   = (r_state == IDLE) ? DMwea    : r_we;
   assign w_sel_oor  = (r_state == IDLE) ? w_in_oor : r_oor;
   assign w_sel_addr = (r_state == IDLE) ? DMaddra  : r_addr;
   assign w_sel_din  = (r_state == IDLE) ? DMdina   : r_din;

   assign w_arr_we = w_acc &  w_sel_we & ~w_sel_oor;
   assign w_arr_re = w_acc & ~w_sel_we & ~w_sel_oor;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (DMena) begin
               w_state_nxt = c_single ? DONE : BUSY;
            end
         end
         BUSY: begin
            if (r_cnt == c_cnt_one) begin
               w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_oor    <= 1'b0;
         r_addr   <= '0;
         r_din    <= '0;
         r_ld_oor <= 1'b0;
      end else begin
         if (r_state == IDLE && DMena) begin
            r_cnt  <= c_cnt_load;
            r_we   <= DMwea;
            r_oor  <= w_in_oor;
            r_addr <= DMaddra;
            r_din  <= DMdina;
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 1'b1;
         end
         // Out-of-range loads read as zero until the next load.
         if (w_acc && !w_sel_we) begin
            r_ld_oor <= w_sel_oor;
         end
      end
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .AW    (ARR_AW),
      .DW    (DATA_W)
   ) u_array (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_arr_we),
      .i_re   (w_arr_re),
      .i_addr (w_sel_addr[ARR_AW-1:0]),
      .i_din  (w_sel_din),
      .o_dout (w_arr_dout)
   );

   assign DMdouta = r_ld_oor ? '0 : w_arr_dout;
   assign DMdone  = (r_state == DONE);
   assign DMerr   = (r_state == DONE) && r_oor;

`ifdef DMEM_STATS_EN
   logic [STAT_W-1:0] r_ld_cnt;
   logic [STAT_W-1:0] r_st_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ld_cnt <= '0;
         r_st_cnt <= '0;
      end else if (r_state == DONE) begin
         if (r_we) begin
            if (r_st_cnt != '1) r_st_cnt <= r_st_cnt + 1'b1;
         end else begin
            if (r_ld_cnt != '1) r_ld_cnt <= r_ld_cnt + 1'b1;
         end
      end
   end

   assign ld_count = r_ld_cnt;
   assign st_count = r_st_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_latency_ctrl.sv
// ============================================================================
// tb_dmem_latency_ctrl : randomized self-checking bench for dmem_latency_ctrl
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_latency_ctrl;

   localparam int L = 3;
   localparam int D = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        DMena;
   logic        DMwea;
   logic [6:0]  DMaddra;
   logic [31:0] DMdina;
   logic [31:0] DMdouta;
   logic        DMdone;
   logic        DMerr;
`ifdef DMEM_STATS_EN
   logic [15:0] ld_count;
   logic [15:0] st_count;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: word store with written flags, last load value, counts.
   logic [31:0] m_mem [128];
   bit          m_val [128];
   logic [31:0] m_last;
   bit          m_known;
   int          m_ld;
   int          m_st;

   dmem_latency_ctrl #(
      .LATENCY   (L),
      .DEPTH     (D),
      .INIT_ZERO (1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .DMena   (DMena),
      .DMwea   (DMwea),
      .DMaddra (DMaddra),
      .DMdina  (DMdina),
      .DMdouta (DMdouta),
      .DMdone  (DMdone),
      .DMerr   (DMerr)
`ifdef DMEM_STATS_EN
      ,
      .ld_count (ld_count),
      .st_count (st_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic void m_reset();
      m_last  = 32'h0;
      m_known = 1'b1;
      m_ld    = 0;
      m_st    = 0;
   endfunction

   function automatic void m_apply(input bit we, input int a, input logic [31:0] d);
      if (we) begin
         if (a < D) begin
            m_mem[a] = d;
            m_val[a] = 1'b1;
         end
         m_st++;
      end else begin
         if (a >= D) begin
            m_last  = 32'h0;
            m_known = 1'b1;
         end else begin
            m_last  = m_mem[a];
            m_known = m_val[a];
         end
         m_ld++;
      end
   endfunction

   // Drives one request and reports what the DUT did; callers judge it.
   task automatic do_req(input bit we, input logic [6:0] a, input logic [31:0] d,
                         input bit scr, output int lat, output logic [31:0] q,
                         output logic e, output logic extra);
      @(negedge clk);
      DMena = 1'b1; DMwea = we; DMaddra = a; DMdina = d;
      @(posedge clk);
      lat = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (DMdone === 1'b1 || lat >= 40) break;
         if (scr) begin
            DMena = 1'($urandom); DMwea = 1'($urandom);
            DMaddra = 7'($urandom); DMdina = $urandom;
         end else begin
            DMena = 1'b0;
         end
      end
      q = DMdouta;
      e = DMerr;
      @(negedge clk);
      extra = DMdone;
      DMena = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; DMena = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1; DMena = 1'b0; DMwea = 1'b0; DMaddra = '0; DMdina = '0;
      for (int i = 0; i < 128; i++) m_val[i] = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (DMdone !== 1'b0 || DMerr !== 1'b0 || DMdouta !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got done=%b err=%b dout=%h want 0/0/0",
                     i, DMdone, DMerr, DMdouta);
         end
      end
   endtask

   task automatic test_store_load();
      int lat; logic [31:0] q; logic e, x;
      do_req(1'b1, 7'd5, 32'hDEADBEEF, 1'b0, lat, q, e, x);
      m_apply(1'b1, 5, 32'hDEADBEEF);
      total++;
      if (lat !== L || x !== 1'b0) begin
         bad++; $display("FAIL st5_latency got lat=%0d extra=%b want %0d/0", lat, x, L);
      end
      do_req(1'b0, 7'd5, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 5, 32'h0);
      total++;
      if (lat !== L || x !== 1'b0) begin
         bad++; $display("FAIL ld5_latency got lat=%0d extra=%b want %0d/0", lat, x, L);
      end
      total++;
      if (q !== 32'hDEADBEEF || e !== 1'b0) begin
         bad++; $display("FAIL ld5_data got %h err=%b want deadbeef err=0", q, e);
      end
   endtask

   task automatic test_hold_ena();
      int lat; logic [31:0] q; logic e, x;
      int pulses, last_i, i;
      pulses = 0; last_i = 0; i = 0;
      do_req(1'b1, 7'd9, 32'h0909_1234, 1'b0, lat, q, e, x);
      m_apply(1'b1, 9, 32'h0909_1234);
      @(negedge clk);
      DMena = 1'b1; DMwea = 1'b0; DMaddra = 7'd9; DMdina = $urandom;
      while (pulses < 6 && i < 80) begin
         @(negedge clk);
         i++;
         if (DMdone === 1'b1) begin
            pulses++;
            m_apply(1'b0, 9, 32'h0);
            total++;
            if ((pulses == 1 && i != L) || (pulses > 1 && i - last_i != L + 1)) begin
               bad++;
               $display("FAIL hold_gap pulse=%0d got cyc=%0d prev=%0d want gap %0d",
                        pulses, i, last_i, (pulses == 1) ? L : L + 1);
            end
            total++;
            if (DMdouta !== m_last) begin
               bad++; $display("FAIL hold_data got %h want %h", DMdouta, m_last);
            end
            last_i = i;
            if (pulses == 6) DMena = 1'b0;
         end
      end
      DMena = 1'b0;
      total++;
      if (pulses !== 6) begin
         bad++; $display("FAIL hold_pulses got %0d want 6", pulses);
      end
      @(negedge clk);
      total++;
      if (DMdone !== 1'b0) begin
         bad++; $display("FAIL hold_after got done=%b want 0", DMdone);
      end
   endtask

   task automatic test_mid_busy_change();
      int lat; logic [31:0] q; logic e, x;
      do_req(1'b1, 7'd4, 32'h4444_4444, 1'b0, lat, q, e, x);
      m_apply(1'b1, 4, 32'h4444_4444);
      @(negedge clk);
      DMena = 1'b1; DMwea = 1'b1; DMaddra = 7'd3; DMdina = 32'h1;
      @(posedge clk);
      @(negedge clk);
      DMaddra = 7'd4; DMdina = 32'h2;
      lat = 1;
      while (DMdone !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      @(negedge clk);
      DMena = 1'b0;
      m_apply(1'b1, 3, 32'h1);
      total++;
      if (lat !== L) begin
         bad++; $display("FAIL midbusy_latency got %0d want %0d", lat, L);
      end
      do_req(1'b0, 7'd3, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 3, 32'h0);
      total++;
      if (q !== m_last) begin
         bad++; $display("FAIL midbusy_addr3 got %h want %h", q, m_last);
      end
      do_req(1'b0, 7'd4, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 4, 32'h0);
      total++;
      if (q !== m_last) begin
         bad++; $display("FAIL midbusy_addr4 got %h want %h", q, m_last);
      end
   endtask

   task automatic test_reset_mid_busy();
      int lat; logic [31:0] q; logic e, x;
      do_req(1'b1, 7'd7, 32'hAAAA_0000, 1'b0, lat, q, e, x);
      m_apply(1'b1, 7, 32'hAAAA_0000);
      do_req(1'b0, 7'd7, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 7, 32'h0);
      @(negedge clk);
      DMena = 1'b1; DMwea = 1'b1; DMaddra = 7'd7; DMdina = 32'h5555_5555;
      @(posedge clk);
      @(negedge clk);
      DMena = 1'b0;
      rst = 1'b1;
      #1;
      total++;
      if (DMdone !== 1'b0 || DMerr !== 1'b0 || DMdouta !== 32'h0) begin
         bad++;
         $display("FAIL rst_busy_outputs got done=%b err=%b dout=%h want 0/0/0",
                  DMdone, DMerr, DMdouta);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_reset();
      do_req(1'b0, 7'd7, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 7, 32'h0);
      total++;
      if (q !== m_last || lat !== L) begin
         bad++; $display("FAIL rst_busy_addr7 got %h lat=%0d want %h lat=%0d", q, lat, m_last, L);
      end
   endtask

   task automatic test_out_of_range();
      int lat; logic [31:0] q; logic e, x;
      do_req(1'b1, 7'd36, 32'h3636_3636, 1'b0, lat, q, e, x);
      m_apply(1'b1, 36, 32'h3636_3636);
      do_req(1'b1, 7'd100, 32'hBAD0_0BAD, 1'b0, lat, q, e, x);
      m_apply(1'b1, 100, 32'hBAD0_0BAD);
      total++;
      if (e !== 1'b1 || lat !== L) begin
         bad++; $display("FAIL oor_store got err=%b lat=%0d want 1/%0d", e, lat, L);
      end
      do_req(1'b0, 7'd100, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 100, 32'h0);
      total++;
      if (q !== 32'h0 || e !== 1'b1) begin
         bad++; $display("FAIL oor_load got %h err=%b want 0 err=1", q, e);
      end
      do_req(1'b0, 7'd36, 32'h0, 1'b0, lat, q, e, x);
      m_apply(1'b0, 36, 32'h0);
      total++;
      if (q !== m_last || e !== 1'b0) begin
         bad++; $display("FAIL oor_alias got %h err=%b want %h err=0", q, e, m_last);
      end
      do_req(1'b1, 7'd10, 32'h1010_1010, 1'b0, lat, q, e, x);
      m_apply(1'b1, 10, 32'h1010_1010);
      total++;
      if (q !== m_last) begin
         bad++; $display("FAIL dout_hold got %h want %h", q, m_last);
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] q; logic e, x;
      bit we, scr; logic [6:0] a; logic [31:0] d;
      for (int n = 0; n < 80; n++) begin
         we  = 1'($urandom);
         scr = 1'($urandom);
         a   = (($urandom % 4) == 0) ? 7'($urandom) : 7'($urandom % 8);
         d   = $urandom;
         do_req(we, a, d, scr, lat, q, e, x);
         m_apply(we, int'(a), d);
         total++;
         if (lat !== L || x !== 1'b0 || e !== (int'(a) >= D)) begin
            bad++;
            $display("FAIL rnd_ctrl n=%0d got lat=%0d extra=%b err=%b want %0d/0/%b",
                     n, lat, x, e, L, (int'(a) >= D));
         end
         if (m_known) begin
            total++;
            if (q !== m_last) begin
               bad++; $display("FAIL rnd_data n=%0d a=%0d we=%b got %h want %h", n, a, we, q, m_last);
            end
         end
      end
`ifdef DMEM_STATS_EN
      total++;
      if (ld_count !== 16'(m_ld) || st_count !== 16'(m_st)) begin
         bad++;
         $display("FAIL rnd_counts got ld=%0d st=%0d want ld=%0d st=%0d",
                  ld_count, st_count, m_ld, m_st);
      end
`endif
   endtask

`ifdef DMEM_STATS_EN
   task automatic test_stats();
      int lat; logic [31:0] q; logic e, x;
      do_reset();
      total++;
      if (ld_count !== 16'h0 || st_count !== 16'h0) begin
         bad++; $display("FAIL stats_reset got ld=%0d st=%0d want 0/0", ld_count, st_count);
      end
      do_req(1'b1, 7'd1, 32'h11, 1'b0, lat, q, e, x);
      do_req(1'b1, 7'd2, 32'h22, 1'b0, lat, q, e, x);
      do_req(1'b0, 7'd1, 32'h0, 1'b0, lat, q, e, x);
      do_req(1'b0, 7'd2, 32'h0, 1'b0, lat, q, e, x);
      do_req(1'b0, 7'd120, 32'h0, 1'b0, lat, q, e, x);
      total++;
      if (ld_count !== 16'd3 || st_count !== 16'd2) begin
         bad++; $display("FAIL stats_count got ld=%0d st=%0d want 3/2", ld_count, st_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_store_load();
      test_hold_ena();
      test_mid_busy_change();
      test_reset_mid_busy();
      test_out_of_range();
      test_random();
`ifdef DMEM_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
